// File: rtl/muon_daq_pkg.sv
// Shared types for the muon-daq self-test sequencer.
// The state encoding is exported so status-register decode can name the states.
package muon_daq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FIRE      = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_GAP       = 3'd3,
        ST_DONE      = 3'd4
    } seq_state_t;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_GAP_W       = 16;
    localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the gap and trigger-timeout periods.
// zero_o is combinational on the count so the FSM sees the last cycle of a period.
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (en_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/test_pattern_sequencer.sv
// Self-test sequencer for the test-pattern generator: fires start pulses, waits for
// each trigger with a timeout, and tallies hits and misses.
//
// state      | meaning
// IDLE       | waiting for run_i
// FIRE       | issue one start pulse (start_o follows one cycle later)
// WAIT_TRIG  | waiting for trigger_i, timeout timer running
// GAP        | inter-event spacing, gap timer running
// DONE       | run finished, done_o pulses on the following cycle
module test_pattern_sequencer
    import muon_daq_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GAP_W       = DEF_GAP_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             run_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] n_events_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             trigger_i,
    output logic             start_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic             timeout_o
);

    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int TMR_W = (GAP_W > TO_W) ? GAP_W : TO_W;
    localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_n_events;
    logic [CNT_W-1:0] r_sent;
    logic [GAP_W-1:0] r_gap;

    logic             w_tmr_load;
    logic             w_tmr_en;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_zero;
    logic             w_run_accept;
    logic             w_hit;
    logic             w_miss;

    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .aresetn    (aresetn),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .en_i       (w_tmr_en),
        .zero_o     (w_tmr_zero)
    );

    // Timer is loaded with N-1 so zero marks the Nth cycle of the period.
    always_comb begin
        w_state_nxt  = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_en     = 1'b0;
        w_tmr_val    = TO_LOAD;
        w_run_accept = 1'b0;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run_i) begin
                    w_run_accept = 1'b1;
                    w_state_nxt  = (n_events_i == '0) ? ST_DONE : ST_FIRE;
                end
            end
            ST_FIRE: begin
                w_tmr_load  = 1'b1;
                w_state_nxt = abort_i ? ST_DONE : ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
                w_tmr_en = 1'b1;
                w_hit    = trigger_i;
                w_miss   = !trigger_i && w_tmr_zero;
                if (abort_i) begin
                    w_state_nxt = ST_DONE;
                end else if (w_hit || w_miss) begin
                    if (r_sent == r_n_events) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_gap == '0) begin
                        w_state_nxt = ST_FIRE;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TMR_W'(r_gap - GAP_W'(1));
                    end
                end
            end
            ST_GAP: begin
                w_tmr_en = 1'b1;
                if (abort_i) begin
                    w_state_nxt = ST_DONE;
                end else if (w_tmr_zero) begin
                    w_state_nxt = ST_FIRE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_n_events <= '0;
            r_gap      <= '0;
            r_sent     <= '0;
            start_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            timeout_o  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            start_o <= (r_state == ST_FIRE);
            done_o  <= (r_state == ST_DONE);

            if (w_run_accept) begin
                r_n_events <= n_events_i;
                r_gap      <= gap_i;
                r_sent     <= '0;
                hit_cnt_o  <= '0;
                miss_cnt_o <= '0;
                timeout_o  <= 1'b0;
                busy_o     <= 1'b1;
            end else if (r_state == ST_DONE) begin
                busy_o <= 1'b0;
            end

            if ((r_state == ST_FIRE) && (r_sent != CNT_MAX)) begin
                r_sent <= r_sent + CNT_W'(1);
            end
            if (w_hit && (hit_cnt_o != CNT_MAX)) begin
                hit_cnt_o <= hit_cnt_o + CNT_W'(1);
            end
            if (w_miss) begin
                timeout_o <= 1'b1;
                if (miss_cnt_o != CNT_MAX) begin
                    miss_cnt_o <= miss_cnt_o + CNT_W'(1);
                end
            end
        end
    end

endmodule
